// File: rtl/tqvp_uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1 (by default) serialiser,
// with frame starts gated by a synchronised active-low CTS input.
module tqvp_uart_tx #(
  parameter int COUNT_REG_LEN = 13,
  parameter int PAYLOAD_BITS  = 8,
  parameter int STOP_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     uart_txd,
  input  logic                     uart_cts,
  input  logic                     uart_tx_start,
  input  logic [PAYLOAD_BITS-1:0]  uart_tx_data,
  output logic                     uart_tx_ready,
  output logic                     uart_tx_busy,
  input  logic [COUNT_REG_LEN-1:0] baud_divider
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_DATA0 = 4'd2;
  localparam logic [3:0] ST_LAST  = 4'(1 + PAYLOAD_BITS + STOP_BITS);

  logic                     cts_s0;
  logic                     cts_s1;
  logic                     cts_ok;
  logic [3:0]               state;
  logic [3:0]               state_nxt;
  logic [COUNT_REG_LEN-1:0] cnt;
  logic [COUNT_REG_LEN-1:0] cnt_nxt;
  logic                     hold_valid;
  logic [PAYLOAD_BITS-1:0]  hold_data;
  logic [PAYLOAD_BITS-1:0]  shift_data;
  logic                     accept;
  logic                     load;

  // Line level driven while in a given state; stop bits and idle are mark.
  function automatic logic line_of(input logic [3:0] st, input logic [PAYLOAD_BITS-1:0] sh);
    logic v;
    v = 1'b1;
    if (st == ST_START) v = 1'b0;
    for (int i = 0; i < PAYLOAD_BITS; i++) begin
      if (st == ST_DATA0 + 4'(i)) v = sh[i];
    end
    return v;
  endfunction

  assign cts_ok        = ~cts_s1;
  assign accept        = uart_tx_start & ~hold_valid;
  assign uart_tx_ready = ~hold_valid;
  assign uart_tx_busy  = hold_valid | (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    if (state == ST_IDLE) begin
      cnt_nxt = '0;
      if (hold_valid && cts_ok) begin
        load      = 1'b1;
        state_nxt = ST_START;
      end
    end else if (cnt >= baud_divider) begin
      cnt_nxt   = '0;
      state_nxt = (state == ST_LAST) ? ST_IDLE : state + 4'd1;
    end else begin
      cnt_nxt = cnt + COUNT_REG_LEN'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cts_s0     <= 1'b1;
      cts_s1     <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      hold_valid <= 1'b0;
      uart_txd   <= 1'b1;
    end else begin
      cts_s0 <= uart_cts;
      cts_s1 <= cts_s0;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      if (load) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid <= 1'b1;
      end
      // Registered line value of the state being entered keeps the output glitch-free.
      uart_txd <= line_of(state_nxt, load ? hold_data : shift_data);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) hold_data <= uart_tx_data;
    if (load) shift_data <= hold_data;
  end

endmodule

// File: doc/tqvp_uart_tx.md
# tqvp_uart_tx

UART transmitter peripheral for the TinyQV peripheral set, and the counterpart of the UART receiver. It serialises one byte per frame onto `uart_txd` as 8N1 by default: start bit, LSB-first data, then stop bit(s). It accepts a byte into a one-entry holding register while a previous frame is still shifting. Frame starts are gated by a synchronised active-low CTS input, and it shares the receiver's `baud_divider` convention.

## Interface
- `COUNT_REG_LEN`, 13: width of the bit-period counter and `baud_divider`.
- `PAYLOAD_BITS`, 8: data bits per frame.
- `STOP_BITS`, 1: stop bits per frame.

- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `uart_txd`  out  1  serial line; idle/mark = 1.
- `uart_cts`  in  1  clear-to-send, active low, asynchronous to `clk`.
- `uart_tx_start`  in  1  write strobe; accepted only in a cycle where `uart_tx_ready`=1.
- `uart_tx_data`  in  PAYLOAD_BITS  byte captured on an accepted start.
- `uart_tx_ready`  out  1  holding register empty.
- `uart_tx_busy`  out  1  holding register full, or the FSM is not in IDLE.
- `baud_divider`  in  COUNT_REG_LEN  bit period is `baud_divider`+1 clocks.

## Operation
- Reset values (applied asynchronously): `uart_txd`=1, `uart_tx_ready`=1, `uart_tx_busy`=0.
  - Internal reset state: FSM=IDLE, counter=0, `hold_valid`=0, both CTS synchroniser flops=1 (not clear).
- Holding register:
  - An accepted start sets `hold_valid`=1 and latches `uart_tx_data`.
  - A start strobe while `hold_valid`=1 is ignored; the data is dropped and no state changes.
  - `uart_tx_ready` = !`hold_valid`. `uart_tx_busy` = `hold_valid` | (FSM≠IDLE).
- CTS path: 2-flop synchroniser; `cts_ok` = (synchronised value == 0).
- FSM uses a 4-bit state: IDLE(0), START(1), DATA0..DATA(N-1) (2..N+1), STOP0..STOP(S-1), where N=PAYLOAD_BITS and S=STOP_BITS.
- IDLE:
  - If `hold_valid` & `cts_ok`: move hold data into the shift register, clear `hold_valid`, zero the counter, go to START.
  - Otherwise stay in IDLE.
- START, DATAk and STOPk each last exactly `baud_divider`+1 cycles.
  - Counter increments from 0. A bit ends when counter >= `baud_divider`; the counter then returns to 0 and the state advances.
- Line value per state: START=0; DATAk = shift register bit k (LSB first); STOP=1; IDLE=1.
- After the last STOP bit: return to IDLE.
- CTS is examined only in IDLE. Deasserting CTS mid-frame does not affect the frame in progress.
- The holding register may be refilled at any time during a frame. The shift register is independent of it.
- `baud_divider` is used live. Software changes it only while `uart_tx_busy`=0; a mid-frame change is not required to produce a well-formed frame.

## Timing
- `uart_txd` is a flop, loaded with the line value of the next state on the same edge as the state change, so it is glitch-free.
- Latency, start to line low:
  - Start accepted at edge E0.
  - `hold_valid` is 1 after E0.
  - If `cts_ok`, FSM enters START and `uart_txd` falls at E1.
- Frame length: (1+N+S)·(`baud_divider`+1) cycles, measured from the `uart_txd` fall.
- Back-to-back frames, with hold full and `cts_ok`:
  - Exactly one IDLE cycle sits between the end of the last stop bit and the next start bit.
  - The line stays 1 through that cycle, so the gap is one extra mark cycle.
- A load in IDLE and a start strobe in the same cycle: `uart_tx_ready` was 0, so the strobe is ignored.
- `uart_tx_ready` rises one cycle after the load edge.
- `baud_divider`=0: every bit lasts 1 cycle, and the frame is 10 cycles for 8N1.
- `resetn` low mid-frame: `uart_txd`=1 immediately (asynchronous), hold is discarded, FSM=IDLE.
- After `resetn` rises, the earliest `uart_txd` fall is E0+1, provided `uart_cts` has been low for at least 2 clock edges.

## Test plan
- Divider=3, `uart_cts`=0, start with 0xA5 → `uart_txd` one cycle later shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). `uart_tx_busy` falls after the stop bit.
- Back-to-back frames: 0x00 while idle, then 0xFF while the first frame is shifting → two complete frames separated by exactly 1 extra mark cycle; `uart_tx_ready` is 1 between the loads.
- `uart_cts`=1, start with 0x3C → line stays 1, ready=0, busy=1. Drop `uart_cts` → `uart_txd` falls 3 cycles later (2 synchroniser + 1 FSM). Raise `uart_cts` mid-frame → the frame completes.
- Fill hold (0x11) while frame 0x22 is running, then strobe 0x33 → 0x33 is dropped; the line carries 0x22 then 0x11 only.
- Divider=0, start 0x81 → 10-cycle frame 0,1,0,0,0,0,0,0,1,1.
- Assert `resetn`=0 during DATA3 → `uart_txd`=1 the same cycle, ready=1, busy=0. After release, a new start transmits correctly.
